// File: rtl/shift_unit_seq.sv
// Sequential barrel-shift unit: one shift stage per clock, fixed latency.
// Ports: clk_i/rst_i, in_valid_i/in_ready_o + data_i/shamt_i/op_i request,
//        out_valid_o/out_ready_i + data_o/zero_o result, busy_o status.
module shift_unit_seq #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               in_valid_i,
   output logic               in_ready_o,
   input  logic [WIDTH-1:0]   data_i,
   input  logic [SHAMT_W-1:0] shamt_i,
   input  logic [1:0]         op_i,
   output logic               out_valid_o,
   input  logic               out_ready_i,
   output logic [WIDTH-1:0]   data_o,
   output logic               zero_o,
   output logic               busy_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

   localparam logic [1:0] OP_SLL = 2'b00;
   localparam logic [1:0] OP_SRL = 2'b01;
   localparam logic [1:0] OP_SRA = 2'b10;
   localparam logic [1:0] OP_ROR = 2'b11;

   localparam logic [SHAMT_W-1:0] K_LAST = SHAMT_W'(SHAMT_W - 1);

   state_e             state_q, state_d;
   logic [SHAMT_W-1:0] k_q, k_d;
   logic [WIDTH-1:0]   word_q, word_d;
   logic [SHAMT_W-1:0] shamt_q, shamt_d;
   logic [1:0]         op_q, op_d;
   logic [WIDTH-1:0]   data_q, data_d;
   logic               zero_q, zero_d;

   logic [SHAMT_W-1:0] amt;
   logic [SHAMT_W:0]   ramt;
   logic               sel;
   logic [WIDTH-1:0]   step;

   // Stage k shifts by 2^k; the complement is only used by the rotate.
   always_comb begin
      amt  = SHAMT_W'(1) << k_q;
      ramt = (SHAMT_W+1)'(WIDTH) - {1'b0, amt};
      sel  = |(shamt_q & amt[SHAMT_W-1:0]);
      step = word_q;
      unique case (op_q)
         OP_SLL: step = word_q << amt;
         OP_SRL: step = word_q >> amt;
         OP_SRA: step = $unsigned($signed(word_q) >>> amt);
         OP_ROR: step = (word_q >> amt) | (word_q << ramt);
         default: step = word_q;
      endcase
   end

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      word_d  = word_q;
      shamt_d = shamt_q;
      op_d    = op_q;
      data_d  = data_q;
      zero_d  = zero_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid_i && in_ready_o) begin
               word_d  = data_i;
               shamt_d = shamt_i;
               op_d    = op_i;
               k_d     = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (sel) begin
               word_d = step;
            end
            k_d = k_q + 1'b1;
            if (k_q == K_LAST) begin
               k_d     = '0;
               data_d  = word_d;
               zero_d  = (word_d == '0);
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready_i) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= IDLE;
         k_q     <= '0;
         word_q  <= '0;
         shamt_q <= '0;
         op_q    <= '0;
         data_q  <= '0;
         zero_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         word_q  <= word_d;
         shamt_q <= shamt_d;
         op_q    <= op_d;
         data_q  <= data_d;
         zero_q  <= zero_d;
      end
   end

   assign in_ready_o  = (state_q == IDLE) && rst_i;
   assign out_valid_o = (state_q == DONE);
   assign busy_o      = (state_q != IDLE);
   assign data_o      = data_q;
   assign zero_o      = zero_q;

endmodule

// File: tb/tb_shift_unit_seq.sv
// Directed and randomised checks for shift_unit_seq (WIDTH=32).
// Golden model shifts one bit position at a time.
module tb_shift_unit_seq;

   logic        clk_i;
   logic        rst_i;
   logic        in_valid_i;
   logic        in_ready_o;
   logic [31:0] data_i;
   logic [4:0]  shamt_i;
   logic [1:0]  op_i;
   logic        out_valid_o;
   logic        out_ready_i;
   logic [31:0] data_o;
   logic        zero_o;
   logic        busy_o;

   int checks = 0;
   int errors = 0;

   shift_unit_seq #(.WIDTH(32), .SHAMT_W(5)) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .in_valid_i (in_valid_i),
      .in_ready_o (in_ready_o),
      .data_i     (data_i),
      .shamt_i    (shamt_i),
      .op_i       (op_i),
      .out_valid_o(out_valid_o),
      .out_ready_i(out_ready_i),
      .data_o     (data_o),
      .zero_o     (zero_o),
      .busy_o     (busy_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] model(input logic [1:0] op,
                                         input logic [31:0] d,
                                         input logic [4:0] sh);
      logic [31:0] w;
      w = d;
      for (int i = 0; i < 32; i++) begin
         if (i < int'(sh)) begin
            case (op)
               2'b00: w = {w[30:0], 1'b0};
               2'b01: w = {1'b0, w[31:1]};
               2'b10: w = {w[31], w[31:1]};
               default: w = {w[0], w[31:1]};
            endcase
         end
      end
      return w;
   endfunction

   task automatic tick;
      @(posedge clk_i);
      #1;
   endtask

   // Issue one request, check latency/result, hold for 'hold' cycles.
   task automatic do_req(input string tag, input logic [1:0] op,
                         input logic [31:0] d, input logic [4:0] sh,
                         input logic [31:0] exp, input int hold);
      int n;
      in_valid_i = 1'b1;
      op_i       = op;
      data_i     = d;
      shamt_i    = sh;
      n = 0;
      while (!in_ready_o && n < 50) begin
         tick();
         n++;
      end
      chk({tag, "_rdy"}, 32'(in_ready_o), 32'd1);
      tick();
      in_valid_i = 1'b0;
      data_i     = ~d;
      shamt_i    = ~sh;
      op_i       = ~op;
      n = 0;
      while (!out_valid_o && n < 50) begin
         tick();
         n++;
      end
      chk({tag, "_lat"}, 32'(n), 32'd5);
      chk({tag, "_data"}, data_o, exp);
      chk({tag, "_zero"}, 32'(zero_o), 32'(exp == 32'h0));
      for (int i = 0; i < hold; i++) begin
         tick();
         chk({tag, "_hold"}, data_o, exp);
         chk({tag, "_hrdy"}, 32'(in_ready_o), 32'd0);
      end
      out_ready_i = 1'b1;
      tick();
      out_ready_i = 1'b0;
      chk({tag, "_ret"}, 32'(out_valid_o), 32'd0);
      chk({tag, "_keep"}, data_o, exp);
   endtask

   initial begin
      int n;
      int t0;
      int t1;
      logic [1:0]  rop;
      logic [31:0] rd;
      logic [4:0]  rsh;
      rst_i       = 1'b0;
      in_valid_i  = 1'b0;
      out_ready_i = 1'b0;
      data_i      = '0;
      shamt_i     = '0;
      op_i        = '0;
      tick();
      tick();
      chk("rst_data", data_o, 32'h0);
      chk("rst_zero", 32'(zero_o), 32'd1);
      chk("rst_rdy", 32'(in_ready_o), 32'd0);
      chk("rst_vld", 32'(out_valid_o), 32'd0);
      chk("rst_busy", 32'(busy_o), 32'd0);
      rst_i = 1'b1;
      #1;
      chk("rel_rdy", 32'(in_ready_o), 32'd1);

      do_req("sll31", 2'b00, 32'h00000001, 5'd31, 32'h80000000, 0);
      do_req("sra4", 2'b10, 32'h80000000, 5'd4, 32'hF8000000, 0);
      do_req("srl4", 2'b01, 32'h80000000, 5'd4, 32'h08000000, 0);
      do_req("ror1", 2'b11, 32'h00000001, 5'd1, 32'h80000000, 0);
      do_req("sll1z", 2'b00, 32'h80000000, 5'd1, 32'h00000000, 0);
      do_req("sra0", 2'b10, 32'h1234ABCD, 5'd0, 32'h1234ABCD, 0);
      do_req("ror8", 2'b11, 32'h12345678, 5'd8, 32'h78123456, 0);
      do_req("sra31p", 2'b10, 32'h7FFFFFFF, 5'd31, 32'h00000000, 0);
      do_req("sra31n", 2'b10, 32'h80000000, 5'd31, 32'hFFFFFFFF, 0);
      do_req("srl31", 2'b01, 32'hFFFFFFFF, 5'd31, 32'h00000001, 0);
      do_req("ror31", 2'b11, 32'h80000001, 5'd31, 32'h00000003, 0);
      do_req("sll16", 2'b00, 32'h0000FFFF, 5'd16, 32'hFFFF0000, 0);

      // Backpressure with a competing request held during DONE.
      in_valid_i = 1'b1;
      op_i       = 2'b01;
      data_i     = 32'hF0000000;
      shamt_i    = 5'd8;
      tick();
      data_i  = 32'h0000000F;
      op_i    = 2'b00;
      shamt_i = 5'd4;
      n = 0;
      while (!out_valid_o && n < 50) begin
         tick();
         n++;
      end
      chk("bp_lat", 32'(n), 32'd5);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("bp_data", data_o, 32'h00F00000);
         chk("bp_rdy", 32'(in_ready_o), 32'd0);
         chk("bp_vld", 32'(out_valid_o), 32'd1);
      end
      out_ready_i = 1'b1;
      tick();
      out_ready_i = 1'b0;
      in_valid_i  = 1'b0;
      chk("bp_ret", 32'(out_valid_o), 32'd0);
      chk("bp_nocap", 32'(busy_o), 32'd0);
      chk("bp_keep", data_o, 32'h00F00000);

      // Throughput with an always-ready consumer.
      in_valid_i  = 1'b1;
      out_ready_i = 1'b1;
      op_i        = 2'b11;
      data_i      = 32'h0000F00D;
      shamt_i     = 5'd4;
      t0 = -1;
      t1 = -1;
      for (int c = 0; c < 40; c++) begin
         tick();
         if (out_valid_o && t0 < 0) t0 = c;
         else if (out_valid_o && t1 < 0 && c > t0 + 1) t1 = c;
      end
      in_valid_i  = 1'b0;
      tick();
      tick();
      out_ready_i = 1'b0;
      chk("tp_first", 32'(t0), 32'd5);
      chk("tp_period", 32'(t1 - t0), 32'd7);
      chk("tp_data", data_o, 32'hD0000F00);

      // Reset in the second SHIFT cycle aborts the operation.
      in_valid_i = 1'b1;
      op_i       = 2'b00;
      data_i     = 32'h00000003;
      shamt_i    = 5'd2;
      tick();
      in_valid_i = 1'b0;
      tick();
      rst_i = 1'b0;
      #1;
      chk("ar_data", data_o, 32'h0);
      chk("ar_zero", 32'(zero_o), 32'd1);
      chk("ar_busy", 32'(busy_o), 32'd0);
      chk("ar_rdy", 32'(in_ready_o), 32'd0);
      chk("ar_vld", 32'(out_valid_o), 32'd0);
      n = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (out_valid_o) n++;
      end
      chk("ar_novld", 32'(n), 32'd0);
      rst_i = 1'b1;
      #1;
      do_req("ar_after", 2'b10, 32'h90000000, 5'd3, 32'hF2000000, 1);

      // Random regression against the bit-serial model.
      for (int r = 0; r < 300; r++) begin
         rop = 2'($urandom_range(0, 3));
         rd  = $urandom;
         rsh = 5'($urandom_range(0, 31));
         repeat ($urandom_range(0, 2)) tick();
         do_req("rnd", rop, rd, rsh, model(rop, rd, rsh),
                int'($urandom_range(0, 2)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
